// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants, state encoding and address helper for the cacheline adaptor.
// A line is moved as BEATS fixed-width beats on the memory port.
package cacheline_adaptor_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int OFFSET  = $clog2(LINE_W / 8);
    localparam int CNT_W   = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

    // Clears the byte offset so memory always sees the start of the line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET], {OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adaptor_line_shifter.sv
// Line-wide register with parallel load and a beat-wide shift-right/insert-at-top port.
// Serialises a loaded line low beat first, and assembles arriving beats so beat 0 ends up lowest.
module cacheline_adaptor_line_shifter
    import cacheline_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [LINE_W-1:0]  load_data,
    input  logic               shift,
    input  logic [BURST_W-1:0] insert,
    output logic [LINE_W-1:0]  q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {insert, q[LINE_W-1:BURST_W]};
        end
    end

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts cacheline fills and evictions into fixed-length bursts on the memory port.
// Every output is a register; the FSM is a state register plus a next-value block.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    adaptor_state_t    state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              read_n, write_n, resp_n;
    logic [ADDR_W-1:0] address_n;
    logic [LINE_W-1:0] line_n;
    logic [LINE_W-1:0] shift_q;
    logic              load, shift;
    logic              last_beat;

    assign last_beat = (count == CNT_W'(BEATS - 1));

    // One shared register serialises writebacks and assembles fills.
    cacheline_adaptor_line_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (line_i),
        .shift     (shift),
        .insert    (burst_i),
        .q         (shift_q)
    );

    assign burst_o = shift_q[BURST_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            address_o <= '0;
            line_o    <= '0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            read_o    <= read_n;
            write_o   <= write_n;
            resp_o    <= resp_n;
            address_o <= address_n;
            line_o    <= line_n;
        end
    end

    // Writes take priority in IDLE so a dirty victim is evicted before the fill.
    always_comb begin
        state_n   = state;
        count_n   = count;
        read_n    = read_o;
        write_n   = write_o;
        resp_n    = 1'b0;
        address_n = address_o;
        line_n    = line_o;
        load      = 1'b0;
        shift     = 1'b0;

        unique case (state)
            IDLE: begin
                if (write_i) begin
                    load      = 1'b1;
                    address_n = line_align(address_i);
                    count_n   = '0;
                    write_n   = 1'b1;
                    state_n   = WRITE;
                end else if (read_i) begin
                    address_n = line_align(address_i);
                    count_n   = '0;
                    read_n    = 1'b1;
                    state_n   = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    shift   = 1'b1;
                    count_n = count + CNT_W'(1);
                    if (last_beat) begin
                        read_n  = 1'b0;
                        resp_n  = 1'b1;
                        line_n  = {burst_i, shift_q[LINE_W-1:BURST_W]};
                        state_n = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    shift   = 1'b1;
                    count_n = count + CNT_W'(1);
                    if (last_beat) begin
                        write_n = 1'b0;
                        resp_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomised bench for cacheline_adaptor: a transaction-level memory model is checked
// against the DUT every cycle, plus directed scenarios with hand-computed values.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    int testsRun    = 0;
    int testsFailed = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 filling, 2 evicting, 3 completion cycle.
    int                mMode  = 0;
    int                mBeats = 0;
    bit                mValid = 0;
    bit                mResp  = 0;
    logic [ADDR_W-1:0] mAddr;
    logic [LINE_W-1:0] mFill, mWline, mAsm;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mValid = 1;
            mMode  = 0;
            mBeats = 0;
            mResp  = 0;
            mAddr  = '0;
            mFill  = '0;
            mAsm   = '0;
        end else if (mValid) begin
            mResp = 0;
            case (mMode)
                0: begin
                    if (write_i) begin
                        mMode  = 2;
                        mBeats = 0;
                        mAddr  = (address_i / (LINE_W / 8)) * (LINE_W / 8);
                        mWline = line_i;
                    end else if (read_i) begin
                        mMode  = 1;
                        mBeats = 0;
                        mAddr  = (address_i / (LINE_W / 8)) * (LINE_W / 8);
                    end
                end
                1: begin
                    if (resp_i) begin
                        mAsm[mBeats*BURST_W +: BURST_W] = burst_i;
                        mBeats++;
                        if (mBeats == BEATS) begin
                            mFill = mAsm;
                            mResp = 1;
                            mMode = 3;
                        end
                    end
                end
                2: begin
                    if (resp_i) begin
                        mBeats++;
                        if (mBeats == BEATS) begin
                            mResp = 1;
                            mMode = 3;
                        end
                    end
                end
                default: mMode = 0;
            endcase
        end
        if (mValid) begin
            checkOutput("read_o", read_o, (mMode == 1));
            checkOutput("write_o", write_o, (mMode == 2));
            checkOutput("resp_o", resp_o, mResp);
            checkOutput("address_o", address_o, mAddr);
            checkOutput("line_o", line_o, mFill);
            if (mMode == 2)
                checkOutput("burst_o", burst_o, mWline[mBeats*BURST_W +: BURST_W]);
        end
    end

    // Runs one cache request; mask bit n (n>=1) forces resp_i on the n-th busy cycle, 0 means random.
    task automatic applyStimulus(input bit doWrite, input bit doRead, input bit keepRead,
                                 input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                                 input int unsigned mask, output int busyCycles,
                                 output logic [BURST_W-1:0] firstBurst);
        int  given = 0;
        bit  done  = 0;
        busyCycles = 0;
        firstBurst = '0;
        write_i    = doWrite;
        read_i     = doRead;
        address_i  = addr;
        line_i     = data;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (resp_o) begin
                done    = 1;
                write_i = 1'b0;
                read_i  = keepRead;
                resp_i  = ($urandom_range(0, 1) == 1);
                burst_i = {$urandom, $urandom};
            end else if (read_o || write_o) begin
                busyCycles++;
                if (busyCycles == 1)
                    firstBurst = burst_o;
                if (mask == 0) begin
                    resp_i    = ($urandom_range(0, 1) == 1) && (given < BEATS);
                    address_i = $urandom;
                end else begin
                    resp_i = (busyCycles < 32) ? mask[busyCycles] : 1'b0;
                end
                if (resp_i) begin
                    burst_i = data[given*BURST_W +: BURST_W];
                    given++;
                end else begin
                    burst_i = {$urandom, $urandom};
                end
            end else begin
                resp_i  = ($urandom_range(0, 1) == 1);
                burst_i = {$urandom, $urandom};
            end
        end
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL timeout: got no resp_o expected resp_o within 300 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int                busy;
        logic [BURST_W-1:0] fb;
        logic [LINE_W-1:0]  data;
        logic [LINE_W-1:0]  lastFill;

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_read_o", read_o, 1'b0);
        checkOutput("reset_write_o", write_o, 1'b0);
        checkOutput("reset_resp_o", resp_o, 1'b0);
        checkOutput("reset_address_o", address_o, 32'h0);
        checkOutput("reset_burst_o", burst_o, 64'h0);
        checkOutput("reset_line_o", line_o, 256'h0);

        // Basic fill with back-to-back beats.
        data = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        applyStimulus(0, 1, 0, 32'h0000_1234, data, 32'h1E, busy, fb);
        checkOutput("fill_address", address_o, 32'h0000_1220);
        checkOutput("fill_read_cycles", busy, 4);
        checkOutput("fill_line", line_o, data);

        // Writeback, beats A..D with A in the low 64 bits.
        data = {64'hDEAD_BEEF_0000_000D, 64'hDEAD_BEEF_0000_000C,
                64'hDEAD_BEEF_0000_000B, 64'hDEAD_BEEF_0000_000A};
        applyStimulus(1, 0, 0, 32'h0000_ABCD, data, 32'h1E, busy, fb);
        checkOutput("wb_address", address_o, 32'h0000_ABC0);
        checkOutput("wb_write_cycles", busy, 4);
        checkOutput("wb_first_beat", fb, 64'hDEAD_BEEF_0000_000A);
        checkOutput("wb_line_kept", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Stalled fill: beats on busy cycles 2, 5, 6 and 9.
        data = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
                64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
        applyStimulus(0, 1, 0, 32'h8000_003F, data, 32'h264, busy, fb);
        checkOutput("stall_read_cycles", busy, 9);
        checkOutput("stall_address", address_o, 32'h8000_0020);
        checkOutput("stall_line", line_o, data);

        // Both requests: eviction first, then the held fill.
        data = {4{64'h5A5A_5A5A_0F0F_0F0F}};
        applyStimulus(1, 1, 1, 32'h0000_4000, data, 32'h1E, busy, fb);
        checkOutput("both_write_cycles", busy, 4);
        data = {64'h0D, 64'h0C, 64'h0B, 64'h0A};
        applyStimulus(0, 1, 0, 32'h0000_4000, data, 32'h1E, busy, fb);
        checkOutput("after_evict_line", line_o, data);

        // Reset after the second fill beat aborts the burst.
        read_i = 1'b1; address_i = 32'h0000_7777;
        @(negedge clk);
        resp_i = 1'b1; burst_i = 64'h1;
        @(negedge clk);
        resp_i = 1'b1; burst_i = 64'h2;
        @(negedge clk);
        resp_i = 1'b0; rst = 1'b1; read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_read_o", read_o, 1'b0);
        checkOutput("abort_resp_o", resp_o, 1'b0);
        checkOutput("abort_line_o", line_o, 256'h0);
        data = {64'hF4, 64'hF3, 64'hF2, 64'hF1};
        applyStimulus(0, 1, 0, 32'h0000_7777, data, 32'h1E, busy, fb);
        checkOutput("abort_refill_address", address_o, 32'h0000_7760);
        checkOutput("abort_refill_line", line_o, data);

        // Spurious memory handshakes while idle change nothing.
        lastFill = data;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
        end
        @(negedge clk);
        resp_i = 1'b0;
        checkOutput("idle_line_kept", line_o, lastFill);
        checkOutput("idle_read_o", read_o, 1'b0);
        checkOutput("idle_write_o", write_o, 1'b0);

        // Random mix of fills and evictions with random stalls.
        for (int t = 0; t < 40; t++) begin
            bit w, r;
            w    = ($urandom_range(0, 2) == 0);
            r    = !w || ($urandom_range(0, 1) == 1);
            data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(w, r, 0, $urandom, data, 0, busy, fb);
            if (!w)
                checkOutput("rand_fill_line", line_o, data);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Memory-side counterpart to the cache data array. It converts 256-bit cacheline fills and evictions into fixed-length 64-bit bursts on the physical memory port.
- Read path: collects 4 beats from memory, then presents one full line to the cache (fill source for the data array).
- Write path: takes one dirty line from the cache and serialises it into 4 beats to memory.
- Sits between the cache controller/datapath and main memory.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits.
- ADDR_W, 32, byte address width.
- Derived: BEATS = LINE_W/BURST_W = 4. OFFSET = log2(LINE_W/8) = 5.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- line_i  in  LINE_W  line to write back (cache side).
- line_o  out  LINE_W  assembled fill line (cache side).
- address_i  in  ADDR_W  cache request byte address.
- read_i  in  1  cache fill request; held until resp_o.
- write_i  in  1  cache writeback request; held until resp_o.
- resp_o  out  1  one-cycle completion pulse to cache.
- burst_i  in  BURST_W  memory read beat.
- burst_o  out  BURST_W  memory write beat.
- address_o  out  ADDR_W  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat handshake; one beat per cycle high.

Behaviour:
- All outputs registered. On rst: state=IDLE, beat count=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE, write_i=1:
  - latch line_i and {address_i[ADDR_W-1:OFFSET], OFFSET'b0}; count=0.
  - next cycle: write_o=1, burst_o=line[63:0]; go to WRITE.
- IDLE, read_i=1 and write_i=0:
  - latch the aligned address; count=0.
  - next cycle: read_o=1; go to READ.
- IDLE, read_i and write_i both high: write serviced; read_i ignored (evict before fill).
- READ, each cycle resp_i=1:
  - line_o[count*BURST_W +: BURST_W] <= burst_i; count++.
  - On the 4th beat: read_o<=0, resp_o<=1, go to DONE.
  - resp_i=0 cycles stall with no state change. Beats need not be consecutive.
- WRITE, each cycle resp_i=1:
  - count++; burst_o advances to the next 64-bit slice (little-endian beat order, beat 0 = bits 63:0).
  - On the 4th beat: write_o<=0, resp_o<=1, go to DONE.
- DONE:
  - resp_o is high for exactly this cycle. line_o is valid this cycle and holds until the next read completes.
  - Go to IDLE unconditionally; requests are not sampled in DONE.
- Latency, read with back-to-back beats: request sampled at T0, read_o high T1..T4, resp_o at T5.
- address_o stays stable for the whole burst.
- resp_i in IDLE or DONE is ignored.
- Request changes while in READ/WRITE are ignored.
- Count wraps to 0 on entering DONE; BEATS must be a power of two.
- rst mid-burst: abort immediately, drop read_o/write_o the next cycle, discard the partial line, no resp_o.

Decomposition:
- Shared cache package:
  - LINE_W, BURST_W, ADDR_W, BEATS, OFFSET constants.
  - adaptor state enum (IDLE, READ, WRITE, DONE).
- Optional sub-module line_shifter: LINE_W register with parallel load and a BURST_W-wide shift/insert port, used for both the read assemble and write serialise paths. Otherwise flat.

Test Plan:
- Reset then read: address_i=0x0000_1234, read_i=1, memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220, read_o high 4 cycles, resp_o single pulse, line_o={0x44..,0x33..,0x22..,0x11..}.
- Write: line_i=0xDEAD…BEEF pattern (beats A,B,C,D), write_i=1, resp_i every cycle -> write_o high 4 cycles, burst_o sequence A,B,C,D (A = bits 63:0), then resp_o pulse.
- Stalled beats: read with resp_i high on cycles 2, 5, 6, 9 after read_o -> 4 beats captured in order, resp_o one cycle after cycle 9, no extra capture on resp_i=0 cycles.
- Simultaneous read_i=write_i=1 -> write burst only, read_o stays 0; after resp_o, hold read_i -> read burst starts next IDLE cycle.
- rst asserted after 2nd read beat -> read_o=0 next cycle, no resp_o, state IDLE; new read completes normally with correct line_o.
- Spurious resp_i in IDLE -> no output change, line_o unchanged.
